// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined binary32 multiplier with valid/ready
// handshakes on both sides. Stage 1 unpacks, stage 2 multiplies the
// significands, stage 3 normalizes, rounds to nearest even and packs.
// The whole pipe advances together; it stalls only when the output
// stage holds a result the consumer is not taking.
module fmul_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  logic adv;

  logic               v1_q;
  logic               s1_q;
  logic [5:0]         flags1_q;
  logic [23:0]        sigA1_q;
  logic [23:0]        sigB1_q;
  logic signed [9:0]  esum1_q;

  logic               s1_d;
  logic [5:0]         flags1_d;
  logic [23:0]        sigA1_d;
  logic [23:0]        sigB1_d;
  logic signed [9:0]  esum1_d;

  logic               v2_q;
  logic               s2_q;
  logic [5:0]         flags2_q;
  logic signed [9:0]  esum2_q;
  logic [47:0]        prod2_q;
  logic [47:0]        prod2_d;

  logic               v3_q;
  logic [31:0]        y_q;
  logic               ovf_q;
  logic [31:0]        y_d;
  logic               ovf_d;

  logic [22:0]        mant;
  logic               guard;
  logic               sticky;
  logic               roundUp;
  logic [23:0]        mantRnd;
  logic [22:0]        mantFin;
  logic signed [10:0] expNorm;
  logic signed [10:0] expFin;
  logic               anyNan;
  logic               anyInf;
  logic               anyZero;

  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

  // Unpack: product sign, per-operand class flags, hidden-bit significands
  // and the biased exponent sum. Flag order is
  // {nanB, nanA, infB, infA, zeroB, zeroA}; denormals count as zero.
  always_comb begin
    s1_d     = x1[31] ^ x2[31];
    flags1_d = {(x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0),
                (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0),
                (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0),
                (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0),
                (x2[30:23] == 8'h00),
                (x1[30:23] == 8'h00)};
    sigA1_d  = {1'b1, x1[22:0]};
    sigB1_d  = {1'b1, x2[22:0]};
    esum1_d  = $signed({2'b00, x1[30:23]}) + $signed({2'b00, x2[30:23]}) - 10'sd127;
  end

  // Full-width significand product; the two leading-bit cases are
  // resolved in the last stage.
  always_comb begin
    prod2_d = {24'd0, sigA1_q} * {24'd0, sigB1_q};
  end

  // Normalize by one position when the product reaches [2,4), round to
  // nearest even, then apply the special-case priority to pick the result.
  always_comb begin
    if (prod2_q[47]) begin
      mant    = prod2_q[46:24];
      guard   = prod2_q[23];
      sticky  = |prod2_q[22:0];
      expNorm = $signed({esum2_q[9], esum2_q}) + 11'sd1;
    end else begin
      mant    = prod2_q[45:23];
      guard   = prod2_q[22];
      sticky  = |prod2_q[21:0];
      expNorm = $signed({esum2_q[9], esum2_q});
    end
    roundUp = guard && (sticky || mant[0]);
    mantRnd = {1'b0, mant} + {23'd0, roundUp};
    expFin  = mantRnd[23] ? (expNorm + 11'sd1) : expNorm;
    mantFin = mantRnd[23] ? 23'd0 : mantRnd[22:0];

    anyNan  = flags2_q[5] || flags2_q[4] ||
              (flags2_q[3] && flags2_q[0]) || (flags2_q[2] && flags2_q[1]);
    anyInf  = flags2_q[3] || flags2_q[2];
    anyZero = flags2_q[1] || flags2_q[0];

    y_d   = {s2_q, expFin[7:0], mantFin};
    ovf_d = 1'b0;
    if (anyNan) begin
      y_d = 32'h7FC00000;
    end else if (anyInf) begin
      y_d = {s2_q, 8'hFF, 23'd0};
    end else if (anyZero) begin
      y_d = {s2_q, 31'd0};
    end else if (expFin >= 11'sd255) begin
      y_d   = {s2_q, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end else if (expFin <= 11'sd0) begin
      y_d = {s2_q, 31'd0};
    end
  end

  // Pipeline registers: every stage loads together when the pipe advances
  // and all hold otherwise; reset empties the pipe and clears the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      s1_q     <= 1'b0;
      flags1_q <= 6'd0;
      sigA1_q  <= 24'd0;
      sigB1_q  <= 24'd0;
      esum1_q  <= 10'sd0;
      v2_q     <= 1'b0;
      s2_q     <= 1'b0;
      flags2_q <= 6'd0;
      esum2_q  <= 10'sd0;
      prod2_q  <= 48'd0;
      v3_q     <= 1'b0;
      y_q      <= 32'd0;
      ovf_q    <= 1'b0;
    end else if (adv) begin
      v1_q     <= in_valid;
      s1_q     <= s1_d;
      flags1_q <= flags1_d;
      sigA1_q  <= sigA1_d;
      sigB1_q  <= sigB1_d;
      esum1_q  <= esum1_d;
      v2_q     <= v1_q;
      s2_q     <= s1_q;
      flags2_q <= flags1_q;
      esum2_q  <= esum1_q;
      prod2_q  <= prod2_d;
      v3_q     <= v2_q;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
